trace_port_capture: RTL

TRACE_PORT_CAPTURE -- requirements
Module: trace_port_capture

---
 rtl/trace_capture_pkg.sv | 16 +
 rtl/trace_capture_fifo.sv | 56 +++++
 rtl/trace_port_capture.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/trace_capture_pkg.sv
// trace_capture_pkg -- shared definitions for the TPIU trace capture block.
//   state_t            : capture FSM states (IDLE, HUNT, LOCKED)
//   FIFO_DEPTH_DEFAULT : default output byte FIFO depth
//   SYNC_WORD_DEFAULT  : default TPIU full-sync word (low nibble arrives first)
package trace_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HUNT   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam int unsigned FIFO_DEPTH_DEFAULT = 16;
    localparam logic [31:0] SYNC_WORD_DEFAULT  = 32'h7FFF_FFFF;

endpackage

// File: rtl/trace_capture_fifo.sv
// trace_capture_fifo -- synchronous show-ahead FIFO for assembled trace bytes.
//   ext_clock : clock, rising edge
//   reset     : asynchronous active-low reset (pointers only)
//   push      : write request; accepted when not full, or when full with a pop
//   push_data : byte to write
//   pop       : read request; advances the head when not empty
//   head      : current head byte, forced to zero while empty
//   full      : DEPTH entries held
//   empty     : no entries held
module trace_capture_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic             ext_clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             wr_en;
    logic             rd_en;

    // Pointers carry one extra bit so full and empty are distinguishable.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // When full, a simultaneous pop frees the slot being written this edge.
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;

    always_ff @(posedge ext_clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge ext_clock) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/trace_port_capture.sv
// trace_port_capture -- TPIU parallel trace capture: finds the full-sync word,
// aligns nibbles into bytes and queues them in a show-ahead FIFO.
//   ext_clock  : capture clock, rising edge
//   reset      : asynchronous active-low reset
//   trcena     : trace enable; low returns the capture FSM to IDLE
//   tracedata  : 4-bit trace nibble, sampled every cycle
//   clr        : synchronous clear of overflow and statistics
//   m_tdata    : FIFO head byte
//   m_tvalid   : FIFO non-empty
//   m_tready   : downstream accept (pop when m_tvalid & m_tready)
//   locked     : byte alignment established
//   overflow   : sticky, a byte was dropped on a full FIFO
//   byte_count : bytes pushed since reset/clr   (TRACE_CAPTURE_STATS_EN only)
//   sync_count : full-syncs seen since reset/clr (TRACE_CAPTURE_STATS_EN only)
// Optional feature macro: TRACE_CAPTURE_STATS_EN enables the statistics counters.
module trace_port_capture
    import trace_capture_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
    parameter logic [31:0] SYNC_WORD  = SYNC_WORD_DEFAULT
) (
    input  logic        ext_clock,
    input  logic        reset,
    input  logic        trcena,
    input  logic [3:0]  tracedata,
    input  logic        clr,
    output logic [7:0]  m_tdata,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic        locked,
    output logic        overflow
`ifdef TRACE_CAPTURE_STATS_EN
    ,
    output logic [31:0] byte_count,
    output logic [15:0] sync_count
`endif
);

    state_t      state;
    logic        trc_r;
    logic [3:0]  nib_r;
    logic [31:0] window;
    logic [31:0] window_next;
    logic        match;
    logic        phase;
    logic [3:0]  low_nib;
    logic        push;
    logic        pop;
    logic        full;
    logic        empty;
    logic        drop;

    // Input stage.
    always_ff @(posedge ext_clock or negedge reset) begin
        if (!reset) begin
            trc_r <= 1'b0;
            nib_r <= '0;
        end else begin
            trc_r <= trcena;
            nib_r <= tracedata;
        end
    end

    // Newest nibble enters at the top, so a little-endian sync word lines up
    // with SYNC_WORD directly once its last nibble has arrived.
    assign window_next = {nib_r, window[31:4]};
    assign match       = (window_next == SYNC_WORD);

    // A byte completes when the high nibble is processed in LOCKED.
    assign push = (state == ST_LOCKED) && trc_r && phase;
    assign pop  = m_tvalid && m_tready;
    assign drop = push && full && !pop;

    always_ff @(posedge ext_clock or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            locked  <= 1'b0;
            phase   <= 1'b0;
            low_nib <= '0;
            window  <= '0;
        end else begin
            window <= window_next;
            if (!trc_r) begin
                state  <= ST_IDLE;
                locked <= 1'b0;
                phase  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state  <= ST_HUNT;
                        locked <= 1'b0;
                        phase  <= 1'b0;
                    end
                    ST_HUNT: begin
                        if (match) begin
                            state  <= ST_LOCKED;
                            locked <= 1'b1;
                            phase  <= 1'b0;
                        end
                    end
                    ST_LOCKED: begin
                        // A sync realigns: a half-collected byte is discarded.
                        if (match) begin
                            phase <= 1'b0;
                        end else begin
                            if (!phase) low_nib <= nib_r;
                            phase <= ~phase;
                        end
                    end
                    default: begin
                        state  <= ST_IDLE;
                        locked <= 1'b0;
                        phase  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Setting overflow wins over clr in the same cycle.
    always_ff @(posedge ext_clock or negedge reset) begin
        if (!reset)   overflow <= 1'b0;
        else if (drop) overflow <= 1'b1;
        else if (clr)  overflow <= 1'b0;
    end

    trace_capture_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .ext_clock (ext_clock),
        .reset     (reset),
        .push      (push),
        .push_data ({nib_r, low_nib}),
        .pop       (pop),
        .head      (m_tdata),
        .full      (full),
        .empty     (empty)
    );

    assign m_tvalid = !empty;

`ifdef TRACE_CAPTURE_STATS_EN
    logic accepted;
    assign accepted = push && (!full || pop);

    always_ff @(posedge ext_clock or negedge reset) begin
        if (!reset) begin
            byte_count <= '0;
            sync_count <= '0;
        end else begin
            if (clr)           byte_count <= '0;
            else if (accepted) byte_count <= byte_count + 32'd1;
            if (clr)                                 sync_count <= '0;
            else if (match && (sync_count != '1))    sync_count <= sync_count + 16'd1;
        end
    end
`endif

endmodule
